// File: rtl/lp805x_exitmon.sv
// lp805x_exitmon: qualifies the self-test exit code on P0 and latches pass/fail, code and cycle count.
// Optional timeout is enabled by defining LP805X_EXITMON_TIMEOUT_EN.
module lp805x_exitmon #(
   parameter logic [7:0]  IDLE_CODE   = 8'hFF,
   parameter logic [7:0]  PASS_CODE   = 8'h7F,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned STABLE_CYC  = 2,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic [7:0]       port_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic [7:0]       code_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             ovf_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_QUAL, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [3:0]       STABLE_N = 4'(STABLE_CYC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cap_q, cap_d;
   logic [7:0]       cand_q, cand_d;
   logic [3:0]       stable_q, stable_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [7:0]       code_q, code_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic             ovf_q, ovf_d;
   logic             timeout_q, timeout_d;
   logic             accept;

`ifdef LP805X_EXITMON_TIMEOUT_EN
   // Compare at full width so a TIMEOUT_CYC wider than the counter can never match.
   localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;
   logic to_hit;
   assign to_hit = (CMP_W'(count_q) == CMP_W'(TIMEOUT_CYC));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      cap_d     = cap_q;
      cand_d    = cand_q;
      stable_d  = stable_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      code_d    = code_q;
      cycles_d  = cycles_q;
      ovf_d     = ovf_q;
      timeout_d = timeout_q;
      accept    = 1'b0;

      if (clear_i) begin
         state_d   = ST_IDLE;
         count_d   = '0;
         cap_d     = '0;
         cand_d    = '0;
         stable_d  = '0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         code_d    = '0;
         cycles_d  = '0;
         ovf_d     = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
                  count_d = '0;
               end
            end
            ST_RUN, ST_QUAL: begin
               if (start_i) begin
                  state_d  = ST_RUN;
                  count_d  = '0;
                  cap_d    = '0;
                  cand_d   = '0;
                  stable_d = '0;
                  ovf_d    = 1'b0;
               end else begin
                  if (count_q == CNT_MAX) begin
                     ovf_d = 1'b1;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end

                  if (state_q == ST_RUN) begin
                     if (port_i != IDLE_CODE) begin
                        cand_d   = port_i;
                        cap_d    = count_q;
                        stable_d = 4'd1;
                        if (STABLE_N == 4'd1) begin
                           accept = 1'b1;
                        end else begin
                           state_d = ST_QUAL;
                        end
                     end
                  end else begin
                     if (port_i == cand_q) begin
                        stable_d = stable_q + 4'd1;
                        if (stable_q + 4'd1 == STABLE_N) begin
                           accept = 1'b1;
                        end
                     end else if (port_i == IDLE_CODE) begin
                        state_d  = ST_RUN;
                        stable_d = '0;
                        cap_d    = '0;
                     end else begin
                        cand_d   = port_i;
                        cap_d    = count_q;
                        stable_d = 4'd1;
                     end
                  end

                  if (accept) begin
                     state_d  = ST_DONE;
                     done_d   = 1'b1;
                     code_d   = cand_d;
                     cycles_d = cap_d;
                     pass_d   = (cand_d == PASS_CODE);
                     fail_d   = (cand_d != PASS_CODE);
                  end
`ifdef LP805X_EXITMON_TIMEOUT_EN
                  else if (to_hit) begin
                     state_d   = ST_DONE;
                     done_d    = 1'b1;
                     pass_d    = 1'b0;
                     fail_d    = 1'b1;
                     timeout_d = 1'b1;
                     code_d    = 8'h00;
                     cycles_d  = CNT_W'(TIMEOUT_CYC);
                  end
`endif
               end
            end
            default: begin
               // DONE holds everything until clear or reset
            end
         endcase
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_QUAL);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         cap_q     <= '0;
         cand_q    <= '0;
         stable_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         code_q    <= '0;
         cycles_q  <= '0;
         ovf_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         cap_q     <= cap_d;
         cand_q    <= cand_d;
         stable_q  <= stable_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         code_q    <= code_d;
         cycles_q  <= cycles_d;
         ovf_q     <= ovf_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign pass_o    = pass_q;
   assign fail_o    = fail_q;
   assign code_o    = code_q;
   assign cycles_o  = cycles_q;
   assign ovf_o     = ovf_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_lp805x_exitmon.sv
// Bench for lp805x_exitmon: two instances (32-bit/2-sample and 4-bit/1-sample) against a run-length reference model.
module tb_lp805x_exitmon;

   localparam int unsigned S_A = 2;
   localparam int unsigned S_B = 1;
   localparam int unsigned TO  = 50;
`ifdef LP805X_EXITMON_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      int unsigned edge_no;
      logic [7:0]  code;
      logic [31:0] cycles;
      logic        pass;
      logic        fail;
      logic        ovf;
      logic        tmo;
   } exp_t;

   typedef struct {
      bit          armed;
      bit          done;
      int unsigned idx;
      int unsigned rs;
      int unsigned rl;
      logic [7:0]  rv;
   } mdl_t;

   logic        clk = 1'b0;
   logic        rst, start, clear;
   logic [7:0]  port;
   logic        a_busy, a_done, a_pass, a_fail, a_ovf, a_tmo;
   logic [7:0]  a_code;
   logic [31:0] a_cycles;
   logic        b_busy, b_done, b_pass, b_fail, b_ovf, b_tmo;
   logic [7:0]  b_code;
   logic [3:0]  b_cycles;

   int unsigned ecount = 0;
   int          vectors = 0;
   int          errors  = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   mdl_t        mdl[2];

   always #5 clk = ~clk;
   always @(posedge clk) ecount <= ecount + 1;

   lp805x_exitmon #(.CNT_W(32), .STABLE_CYC(S_A), .TIMEOUT_CYC(32'(TO))) dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .clear_i(clear), .port_i(port),
      .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
      .code_o(a_code), .cycles_o(a_cycles), .ovf_o(a_ovf), .timeout_o(a_tmo));

   lp805x_exitmon #(.CNT_W(4), .STABLE_CYC(S_B), .TIMEOUT_CYC(32'(TO))) dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .clear_i(clear), .port_i(port),
      .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
      .code_o(b_code), .cycles_o(b_cycles), .ovf_o(b_ovf), .timeout_o(b_tmo));

   task automatic chk1(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b required %0b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cmp_result(input string tag, input exp_t e, input logic done, input logic pass,
                             input logic fail, input logic busy, input logic ovf, input logic tmo,
                             input logic [7:0] code, input logic [31:0] cycles);
      chk1({tag, "_done"}, done, 1'b1);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_pass"}, pass, e.pass);
      chk1({tag, "_fail"}, fail, e.fail);
      chk1({tag, "_ovf"}, ovf, e.ovf);
      chk1({tag, "_timeout"}, tmo, e.tmo);
      chkw({tag, "_code"}, 32'(code), 32'(e.code));
      chkw({tag, "_cycles"}, cycles, e.cycles);
   endtask

   task automatic mdl_clear(input int inst);
      mdl[inst].armed = 1'b0;
      mdl[inst].done  = 1'b0;
      mdl[inst].idx   = 0;
      mdl[inst].rs    = 0;
      mdl[inst].rl    = 0;
      mdl[inst].rv    = 8'h00;
   endtask

   // Reference: result is the first run of `need` identical non-idle samples since the last start.
   task automatic model_step(input int inst, input bit st, input bit cl, input logic [7:0] p,
                             input int unsigned e);
      longint unsigned maxv, k;
      int unsigned     need;
      exp_t            x;
      maxv = (inst == 0) ? 64'hFFFF_FFFF : 64'hF;
      need = (inst == 0) ? S_A : S_B;
      if (cl) begin
         mdl_clear(inst);
      end else if (!mdl[inst].armed) begin
         if (st) begin
            mdl[inst].armed = 1'b1;
            mdl[inst].idx   = 0;
            mdl[inst].rl    = 0;
         end
      end else if (!mdl[inst].done) begin
         if (st) begin
            mdl[inst].idx = 0;
            mdl[inst].rl  = 0;
         end else begin
            k = mdl[inst].idx;
            if (p != 8'hFF) begin
               if (mdl[inst].rl != 0 && p == mdl[inst].rv) begin
                  mdl[inst].rl++;
               end else begin
                  mdl[inst].rv = p;
                  mdl[inst].rs = 32'(k);
                  mdl[inst].rl = 1;
               end
            end else begin
               mdl[inst].rl = 0;
            end
            x.edge_no = e;
            x.ovf     = (k >= maxv);
            if (mdl[inst].rl == need) begin
               x.code   = mdl[inst].rv;
               x.cycles = (mdl[inst].rs > maxv) ? 32'(maxv) : mdl[inst].rs;
               x.pass   = (mdl[inst].rv == 8'h7F);
               x.fail   = (mdl[inst].rv != 8'h7F);
               x.tmo    = 1'b0;
               mdl[inst].done = 1'b1;
            end else if (TO_EN && k == TO && TO <= maxv) begin
               x.code   = 8'h00;
               x.cycles = TO;
               x.pass   = 1'b0;
               x.fail   = 1'b1;
               x.tmo    = 1'b1;
               mdl[inst].done = 1'b1;
            end
            if (mdl[inst].done) begin
               if (inst == 0) qa.push_back(x);
               else qb.push_back(x);
            end
            mdl[inst].idx = 32'(k + 1);
         end
      end
   endtask

   task automatic cyc(input bit st, input bit cl, input logic [7:0] p);
      @(negedge clk);
      start = st;
      clear = cl;
      port  = p;
      model_step(0, st, cl, p, ecount + 1);
      model_step(1, st, cl, p, ecount + 1);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: pop on each rising done_o, then hold the latched result while done_o stays high.
   logic a_prev = 1'b0, b_prev = 1'b0;
   exp_t a_cur, b_cur;

   always @(negedge clk) begin
      if (a_done === 1'b1 && !a_prev) begin
         if (qa.size() == 0) begin
            chk1("A_spurious_done", a_done, 1'b0);
         end else begin
            a_cur = qa.pop_front();
            chkw("A_done_edge", ecount, a_cur.edge_no);
            cmp_result("A", a_cur, a_done, a_pass, a_fail, a_busy, a_ovf, a_tmo, a_code, a_cycles);
         end
      end else if (a_done === 1'b1) begin
         cmp_result("A_hold", a_cur, a_done, a_pass, a_fail, a_busy, a_ovf, a_tmo, a_code, a_cycles);
      end
      a_prev = (a_done === 1'b1);
   end

   always @(negedge clk) begin
      if (b_done === 1'b1 && !b_prev) begin
         if (qb.size() == 0) begin
            chk1("B_spurious_done", b_done, 1'b0);
         end else begin
            b_cur = qb.pop_front();
            chkw("B_done_edge", ecount, b_cur.edge_no);
            cmp_result("B", b_cur, b_done, b_pass, b_fail, b_busy, b_ovf, b_tmo, b_code, 32'(b_cycles));
         end
      end else if (b_done === 1'b1) begin
         cmp_result("B_hold", b_cur, b_done, b_pass, b_fail, b_busy, b_ovf, b_tmo, b_code, 32'(b_cycles));
      end
      b_prev = (b_done === 1'b1);
   end

   task automatic chk_zero(input string tag);
      chk1({tag, "_A_done"}, a_done, 1'b0);
      chk1({tag, "_A_busy"}, a_busy, 1'b0);
      chk1({tag, "_A_pass"}, a_pass, 1'b0);
      chk1({tag, "_A_fail"}, a_fail, 1'b0);
      chk1({tag, "_A_ovf"}, a_ovf, 1'b0);
      chk1({tag, "_A_timeout"}, a_tmo, 1'b0);
      chkw({tag, "_A_code"}, 32'(a_code), 32'h0);
      chkw({tag, "_A_cycles"}, a_cycles, 32'h0);
      chk1({tag, "_B_done"}, b_done, 1'b0);
      chk1({tag, "_B_busy"}, b_busy, 1'b0);
      chkw({tag, "_B_cycles"}, 32'(b_cycles), 32'h0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clear = 1'b0; port = 8'hFF;
      mdl_clear(0);
      mdl_clear(1);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // Pass code after 100 idle samples; 4-bit instance saturates.
      cyc(1'b1, 1'b0, 8'hFF);
      repeat (100) cyc(1'b0, 1'b0, 8'hFF);
      repeat (3) cyc(1'b0, 1'b0, 8'h7F);
      settle();
      chk1("T1_A_pass", a_pass, 1'b1);
      chk1("T1_A_fail", a_fail, 1'b0);
      chkw("T1_A_code", 32'(a_code), 32'h7F);
      chkw("T1_A_cycles", a_cycles, 32'd100);
      chk1("T1_A_busy", a_busy, 1'b0);
      chk1("T1_B_ovf", b_ovf, 1'b1);
      chkw("T1_B_cycles", 32'(b_cycles), 32'hF);
      chk1("T1_B_pass", b_pass, 1'b1);

      // Failing code from sample 40.
      cyc(1'b0, 1'b1, 8'hFF);
      cyc(1'b1, 1'b0, 8'hFF);
      repeat (40) cyc(1'b0, 1'b0, 8'hFF);
      repeat (3) cyc(1'b0, 1'b0, 8'h03);
      settle();
      chk1("T2_A_fail", a_fail, 1'b1);
      chk1("T2_A_pass", a_pass, 1'b0);
      chkw("T2_A_code", 32'(a_code), 32'h03);
      chkw("T2_A_cycles", a_cycles, 32'd40);

      // One-sample glitch of the pass code, then a real failure code.
      cyc(1'b0, 1'b1, 8'hFF);
      cyc(1'b1, 1'b0, 8'hFF);
      repeat (10) cyc(1'b0, 1'b0, 8'hFF);
      cyc(1'b0, 1'b0, 8'h7F);
      repeat (39) cyc(1'b0, 1'b0, 8'hFF);
      repeat (3) cyc(1'b0, 1'b0, 8'h05);
      settle();
      chkw("T3_A_code", 32'(a_code), 32'h05);
      chkw("T3_A_cycles", a_cycles, 32'd50);
      chkw("T3_B_code", 32'(b_code), 32'h7F);
      chkw("T3_B_cycles", 32'(b_cycles), 32'd10);
      chk1("T3_B_ovf", b_ovf, 1'b0);

      // DONE ignores port and start; clear returns to idle; clear beats start.
      repeat (2) cyc(1'b0, 1'b0, 8'h7F);
      cyc(1'b1, 1'b0, 8'h7F);
      settle();
      chk1("T4_hold_done", a_done, 1'b1);
      chkw("T4_hold_code", 32'(a_code), 32'h05);
      chkw("T4_hold_cycles", a_cycles, 32'd50);
      cyc(1'b0, 1'b1, 8'hFF);
      settle();
      chk_zero("T4_clear");
      cyc(1'b1, 1'b1, 8'hFF);
      settle();
      chk1("T4_clr_prio_busy", a_busy, 1'b0);
      cyc(1'b1, 1'b0, 8'hFF);
      settle();
      chk1("T4_start_busy", a_busy, 1'b1);
      repeat (5) cyc(1'b0, 1'b0, 8'hFF);
      settle();

      // Asynchronous reset in the middle of RUN.
      #2;
      rst = 1'b1;
      #1;
      chk_zero("T5_rst");
      mdl_clear(0);
      mdl_clear(1);
      @(negedge clk);
      rst = 1'b0;

`ifdef LP805X_EXITMON_TIMEOUT_EN
      cyc(1'b1, 1'b0, 8'hFF);
      repeat (52) cyc(1'b0, 1'b0, 8'hFF);
      settle();
      chk1("T6_done", a_done, 1'b1);
      chk1("T6_timeout", a_tmo, 1'b1);
      chk1("T6_fail", a_fail, 1'b1);
      chkw("T6_code", 32'(a_code), 32'h00);
      chkw("T6_cycles", a_cycles, 32'd50);
`endif

      for (int t = 0; t < 30; t++) begin
         logic [7:0]  hold;
         int unsigned r;
         cyc(1'b0, 1'b1, 8'hFF);
         cyc(1'b1, 1'b0, 8'hFF);
         repeat ($urandom_range(0, 25)) cyc(1'b0, 1'b0, 8'hFF);
         hold = 8'hFF;
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               r = $urandom_range(0, 9);
               hold = (r < 4) ? 8'hFF : (r < 6) ? 8'h7F : 8'($urandom);
            end
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0, hold);
         end
      end

      repeat (3) cyc(1'b0, 1'b0, 8'hFF);
      cyc(1'b0, 1'b1, 8'hFF);
      repeat (2) cyc(1'b0, 1'b0, 8'hFF);
      settle();
      chkw("A_pending_results", 32'(qa.size()), 32'd0);
      chkw("B_pending_results", 32'(qb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
